// File: rtl/iob_asym_fifo_pkg.sv
// -----------------------------------------------------------------------------
// iob_asym_fifo_pkg
// Shared helpers for the asymmetric (wide-write / narrow-read) FIFO controller.
// The width ratio, its log2, the wide-side address width and the full-flag
// threshold are all derived here, so the top and the level counter agree.
// Optional feature macro used by the controller: IOB_ASYM_FIFO_CLEAR_EN.
// -----------------------------------------------------------------------------
package iob_asym_fifo_pkg;

    // Larger of two integers.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Smaller of two integers.
    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Number of narrow entries carried by one wide write.
    function automatic int calc_ratio(input int w_data_w, input int r_data_w);
        return max_int(1, w_data_w / r_data_w);
    endfunction

    // log2 of the ratio; the ratio is a power of two.
    function automatic int calc_log2ratio(input int ratio);
        return $clog2(ratio);
    endfunction

    // Wide-side address width. It is clamped to at least one bit so the
    // port declaration stays legal.
    function automatic int calc_w_addr_w(input int r_addr_w, input int log2ratio);
        return max_int(1, r_addr_w - log2ratio);
    endfunction

    // Full asserts once the level exceeds this value, i.e. once fewer than
    // ratio narrow slots are free.
    function automatic int full_threshold(input int r_addr_w, input int ratio);
        return max_int(0, (2 ** r_addr_w) - min_int(ratio, 2 ** r_addr_w));
    endfunction

endpackage

// File: rtl/iob_asym_fifo_lvl_cnt.sv
// -----------------------------------------------------------------------------
// iob_asym_fifo_lvl_cnt
// Occupancy counter in narrow entries plus the registered full/empty flags.
// A wide write adds RATIO and a narrow read subtracts one. Both can happen in
// the same cycle. The flags are computed from the next level, so they are
// exact on the same edge that the level changes.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         synchronous flush (tie low when unused)
//   w_acc, r_acc  accepted write / accepted read this cycle
//   level         occupancy in narrow entries (R_ADDR_W+1 bits)
//   full, empty   registered status flags
// -----------------------------------------------------------------------------
module iob_asym_fifo_lvl_cnt
    import iob_asym_fifo_pkg::*;
#(
    parameter int R_ADDR_W = 7,
    parameter int RATIO    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              w_acc,
    input  logic              r_acc,
    output logic [R_ADDR_W:0] level,
    output logic              full,
    output logic              empty
);

    localparam int                LVL_W     = R_ADDR_W + 1;
    localparam logic [LVL_W-1:0] LVL_ZERO  = LVL_W'(1'b0);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1'b1);
    localparam logic [LVL_W-1:0] RATIO_INC = LVL_W'(RATIO);
    localparam logic [LVL_W-1:0] FULL_THR  = LVL_W'(full_threshold(R_ADDR_W, RATIO));

    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_next_s;
    logic [LVL_W-1:0] add_s;
    logic [LVL_W-1:0] sub_s;
    logic             full_r;
    logic             empty_r;

    // Next occupancy. A write is only accepted while not full, so the sum never exceeds the depth.
    always_comb begin
        add_s        = LVL_ZERO;
        sub_s        = LVL_ZERO;
        if (w_acc) begin
            add_s = RATIO_INC;
        end else begin
            add_s = LVL_ZERO;
        end
        if (r_acc) begin
            sub_s = LVL_ONE;
        end else begin
            sub_s = LVL_ZERO;
        end
        level_next_s = level_r + add_s - sub_s;
    end

    // Level and flag registers. Reset and clear both return to the empty state.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            level_r <= LVL_ZERO;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            level_r <= level_next_s;
            empty_r <= (level_next_s == LVL_ZERO);
            full_r  <= (level_next_s > FULL_THR);
        end
    end

    assign level = level_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/iob_asym_fifo_w_big_ctrl.sv
// -----------------------------------------------------------------------------
// iob_asym_fifo_w_big_ctrl
// FIFO controller for an external wide-write / narrow-read two-port RAM.
// One write stores RATIO narrow entries, with the LSB slice at the lowest
// narrow address. One read returns one narrow entry. The RAM read is
// registered, so r_valid is the accepted read delayed by one cycle, and r_data
// is taken directly from the RAM output.
// Optional macro IOB_ASYM_FIFO_CLEAR_EN adds a 'clear' flush input. Clear has
// priority over same-cycle requests.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   clear                     flush (only with IOB_ASYM_FIFO_CLEAR_EN)
//   w_req, w_data, full       write side
//   r_req, r_data, r_valid    read side
//   empty, level              status (level in narrow entries)
//   mem_w_en/addr/data        RAM write port
//   mem_r_en/addr, mem_r_data RAM read port
// -----------------------------------------------------------------------------
module iob_asym_fifo_w_big_ctrl
    import iob_asym_fifo_pkg::*;
#(
    parameter  int W_DATA_W  = 16,
    parameter  int R_DATA_W  = 8,
    parameter  int R_ADDR_W  = 7,
    localparam int RATIO     = calc_ratio(W_DATA_W, R_DATA_W),
    localparam int LOG2RATIO = calc_log2ratio(RATIO),
    localparam int W_ADDR_W  = calc_w_addr_w(R_ADDR_W, LOG2RATIO)
) (
    input  logic                clk,
    input  logic                rst,
`ifdef IOB_ASYM_FIFO_CLEAR_EN
    input  logic                clear,
`endif
    input  logic                w_req,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                full,
    input  logic                r_req,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_valid,
    output logic                empty,
    output logic [R_ADDR_W:0]   level,
    output logic                mem_w_en,
    output logic [W_ADDR_W-1:0] mem_w_addr,
    output logic [W_DATA_W-1:0] mem_w_data,
    output logic                mem_r_en,
    output logic [R_ADDR_W-1:0] mem_r_addr,
    input  logic [R_DATA_W-1:0] mem_r_data
);

    logic                clear_s;
    logic                w_acc_s;
    logic                r_acc_s;
    logic                full_s;
    logic                empty_s;
    logic [W_ADDR_W-1:0] wptr_r;
    logic [R_ADDR_W-1:0] rptr_r;
    logic                r_valid_r;

`ifdef IOB_ASYM_FIFO_CLEAR_EN
    assign clear_s = clear;
`else
    assign clear_s = 1'b0;
`endif

    // Request qualification. Nothing is accepted during reset or a flush, so the RAM stays idle.
    always_comb begin
        w_acc_s = w_req & ~full_s  & ~rst & ~clear_s;
        r_acc_s = r_req & ~empty_s & ~rst & ~clear_s;
    end

    // Pointers wrap naturally at their widths, and r_valid tracks the registered RAM read.
    always_ff @(posedge clk) begin
        if (rst || clear_s) begin
            wptr_r    <= W_ADDR_W'(1'b0);
            rptr_r    <= R_ADDR_W'(1'b0);
            r_valid_r <= 1'b0;
        end else begin
            if (w_acc_s) begin
                wptr_r <= wptr_r + W_ADDR_W'(1'b1);
            end else begin
                wptr_r <= wptr_r;
            end
            if (r_acc_s) begin
                rptr_r <= rptr_r + R_ADDR_W'(1'b1);
            end else begin
                rptr_r <= rptr_r;
            end
            r_valid_r <= r_acc_s;
        end
    end

    iob_asym_fifo_lvl_cnt #(
        .R_ADDR_W (R_ADDR_W),
        .RATIO    (RATIO)
    ) u_lvl_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_s),
        .w_acc (w_acc_s),
        .r_acc (r_acc_s),
        .level (level),
        .full  (full_s),
        .empty (empty_s)
    );

    assign full       = full_s;
    assign empty      = empty_s;
    assign mem_w_en   = w_acc_s;
    assign mem_w_addr = wptr_r;
    assign mem_w_data = w_data;
    assign mem_r_en   = r_acc_s;
    assign mem_r_addr = rptr_r;
    assign r_valid    = r_valid_r;
    assign r_data     = mem_r_data;

endmodule

// File: tb/tb_iob_asym_fifo_w_big_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iob_asym_fifo_w_big_ctrl
// Bench for the default configuration (16-bit write, 8-bit read, 128 narrow
// entries). A behavioural RAM with a registered read sits on the memory ports.
// Accepted writes push their two bytes (LSB first) into an expected queue. A
// monitor pops one byte whenever r_valid is high and compares it with r_data.
// -----------------------------------------------------------------------------
module tb_iob_asym_fifo_w_big_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_req = 1'b0;
    logic [15:0] w_data = 16'h0000;
    logic        full;
    logic        r_req = 1'b0;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        empty;
    logic [7:0]  level;
    logic        mem_w_en;
    logic [5:0]  mem_w_addr;
    logic [15:0] mem_w_data;
    logic        mem_r_en;
    logic [6:0]  mem_r_addr;
    logic [7:0]  mem_r_data;

    logic [7:0]  ram [0:127];
    logic [7:0]  exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Bench-side view of the FIFO state.
    logic [7:0]  m_level = 8'd0;
    logic [5:0]  m_wptr  = 6'd0;
    logic [6:0]  m_rptr  = 7'd0;
    logic        last_w  = 1'b0;

    iob_asym_fifo_w_big_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .w_req      (w_req),
        .w_data     (w_data),
        .full       (full),
        .r_req      (r_req),
        .r_data     (r_data),
        .r_valid    (r_valid),
        .empty      (empty),
        .level      (level),
        .mem_w_en   (mem_w_en),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data),
        .mem_r_en   (mem_r_en),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data)
    );

    always #5 clk = ~clk;

    // External RAM: wide write with the LSB byte at the even address, and a registered narrow read.
    always @(posedge clk) begin
        if (mem_w_en === 1'b1) begin
            ram[{mem_w_addr, 1'b0}] <= mem_w_data[7:0];
            ram[{mem_w_addr, 1'b1}] <= mem_w_data[15:8];
        end
        if (mem_r_en === 1'b1) begin
            mem_r_data <= ram[mem_r_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each valid read byte against the scoreboard queue.
    always @(negedge clk) begin
        if (r_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("r_valid_unexpected", 32'(r_valid), 32'd0);
            end else begin
                check("r_data", 32'(r_data), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [15:0] wd(input int i, input logic [7:0] tag);
        logic [7:0] b;
        b = 8'(i);
        return {b ^ tag, b};
    endfunction

    // One cycle: drive requests and check the outputs against the bench model.
    task automatic step(input logic w, input logic [15:0] d, input logic r);
        logic ew;
        logic er;
        @(negedge clk);
        w_req  = w;
        w_data = d;
        r_req  = r;
        #1;
        ew = w & (m_level <= 8'd126);
        er = r & (m_level != 8'd0);
        check("level", 32'(level), 32'(m_level));
        check("full",  32'(full),  32'(m_level > 8'd126));
        check("empty", 32'(empty), 32'(m_level == 8'd0));
        check("mem_w_en", 32'(mem_w_en), 32'(ew));
        check("mem_r_en", 32'(mem_r_en), 32'(er));
        if (ew) begin
            check("mem_w_addr", 32'(mem_w_addr), 32'(m_wptr));
            check("mem_w_data", 32'(mem_w_data), 32'(d));
            exp_q.push_back(d[7:0]);
            exp_q.push_back(d[15:8]);
            m_wptr = m_wptr + 6'd1;
        end
        if (er) begin
            check("mem_r_addr", 32'(mem_r_addr), 32'(m_rptr));
            m_rptr = m_rptr + 7'd1;
        end
        m_level = m_level + (ew ? 8'd2 : 8'd0) - (er ? 8'd1 : 8'd0);
        last_w  = ew;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_level = 8'd0;
        m_wptr  = 6'd0;
        m_rptr  = 7'd0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && m_level != 8'd0; k++) begin
            step(1'b0, 16'h0000, 1'b1);
        end
        check("drain_level", 32'(m_level), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] wp0;
        logic [6:0] rp0;
        int         nwr;

        // Reset for two cycles while both requests are asserted.
        @(negedge clk);
        rst = 1'b1; w_req = 1'b1; r_req = 1'b1; w_data = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_level",    32'(level),    32'd0);
        check("rst_mem_w_en", 32'(mem_w_en), 32'd0);
        check("rst_mem_r_en", 32'(mem_r_en), 32'd0);
        check("rst_r_valid",  32'(r_valid),  32'd0);
        model_clear();
        rst = 1'b0; w_req = 1'b0; r_req = 1'b0;

        // Single write, then two reads: LSB byte first.
        step(1'b1, 16'hBBAA, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        check("rd0_addr", 32'(mem_r_addr), 32'd0);
        step(1'b0, 16'h0000, 1'b1);
        check("rd1_addr", 32'(mem_r_addr), 32'd1);
        step(1'b0, 16'h0000, 1'b0);
        check("empty_after_reads", 32'(empty), 32'd1);

        // Fill with 64 back-to-back writes.
        for (int i = 0; i < 64; i++) begin
            step(1'b1, wd(i, 8'h5A), 1'b0);
        end
        step(1'b0, 16'h0000, 1'b0);
        check("fill_level", 32'(level), 32'd128);
        check("fill_full",  32'(full),  32'd1);
        step(1'b1, 16'hDEAD, 1'b0);
        check("write65_mem_w_en", 32'(mem_w_en), 32'd0);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b0);
        check("lvl127_level", 32'(level), 32'd127);
        check("lvl127_full",  32'(full),  32'd1);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b0);
        check("lvl126_level", 32'(level), 32'd126);
        check("lvl126_full",  32'(full),  32'd0);
        drain();

        // Simultaneous read and write from level 10.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, wd(i, 8'hC3), 1'b0);
        end
        wp0 = m_wptr;
        rp0 = m_rptr;
        for (int i = 5; i < 10; i++) begin
            step(1'b1, wd(i, 8'hC3), 1'b1);
        end
        step(1'b0, 16'h0000, 1'b0);
        check("simul_level", 32'(level), 32'd15);
        step(1'b1, wd(10, 8'hC3), 1'b1);
        check("simul_wptr", 32'(mem_w_addr), 32'(wp0 + 6'd5));
        check("simul_rptr", 32'(mem_r_addr), 32'(rp0 + 7'd5));
        drain();

        // Stream 300 wide words with a reader that runs continuously (both pointers wrap).
        nwr = 0;
        for (int cyc = 0; cyc < 2000 && nwr < 300; cyc++) begin
            step(1'b1, wd(nwr, 8'h3C), 1'b1);
            if (last_w) nwr++;
        end
        check("wrap_words", 32'(nwr), 32'd300);
        drain();

        // Underflow: a read while empty is ignored.
        step(1'b0, 16'h0000, 1'b1);
        check("underflow_mem_r_en", 32'(mem_r_en), 32'd0);
        step(1'b0, 16'h0000, 1'b0);
        check("underflow_r_valid", 32'(r_valid), 32'd0);

        // Reset in the cycle after an accepted read.
        step(1'b1, 16'h5A3C, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        rst = 1'b1; r_req = 1'b0; w_req = 1'b0;
        #1;
        model_clear();
        @(negedge clk);
        #1;
        check("midrst_r_valid", 32'(r_valid), 32'd0);
        check("midrst_level",   32'(level),   32'd0);
        check("midrst_empty",   32'(empty),   32'd1);
        rst = 1'b0;

        // Recovery after reset: the pointers restart from zero.
        step(1'b1, 16'h3412, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
